// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: widths, the canonical NOP and the fetch entry layout.
package riscv_pkg;

    localparam int unsigned XLEN = 32;
    localparam int unsigned ILEN = 32;

    // addi x0, x0, 0
    localparam logic [ILEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_if.sv
// Fetch-queue signal bundle: imem port, redirect port and decode handshake.
interface fetch_queue_if
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN  = riscv_pkg::XLEN,
    parameter int unsigned DEPTH = 4
);
    localparam int unsigned CntW = $clog2(DEPTH + 1);

    logic                fetch_en;
    logic [XLEN-1:0]     imem_addr;
    logic [ILEN-1:0]     imem_instr;
    logic                redirect_valid;
    logic [XLEN-1:0]     redirect_pc;
    logic                out_valid;
    logic                out_ready;
    logic [XLEN-1:0]     out_pc;
    logic [XLEN-1:0]     out_pc4;
    logic [ILEN-1:0]     out_instr;
    logic [CntW-1:0]     count;
    logic                misaligned;

    // The fetch queue itself.
    modport slave (
        input  fetch_en, imem_instr, redirect_valid, redirect_pc, out_ready,
        output imem_addr, out_valid, out_pc, out_pc4, out_instr, count, misaligned
    );

    // The surrounding pipeline / memory.
    modport master (
        output fetch_en, imem_instr, redirect_valid, redirect_pc, out_ready,
        input  imem_addr, out_valid, out_pc, out_pc4, out_instr, count, misaligned
    );

endinterface

// File: rtl/fetch_fifo.sv
// Power-of-two synchronous FIFO with explicit occupancy count, single-cycle clear
// and a combinational head.
module fetch_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PtrW = $clog2(DEPTH),
    localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             clear_i,
    input  logic [WIDTH-1:0] wdata_i,
    output logic [WIDTH-1:0] head_o,
    output logic [CntW-1:0]  count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  head_q, head_d, tail_q, tail_d;
    logic [CntW-1:0]  count_q, count_d;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (clear_i) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (push_i) tail_d = tail_q + PtrW'(1);
            if (pop_i)  head_d = head_q + PtrW'(1);
            if (push_i && !pop_i)      count_d = count_q + CntW'(1);
            else if (pop_i && !push_i) count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: count gates every read of it.
    always_ff @(posedge clk) begin
        if (push_i && !clear_i) mem_q[tail_q] <= wdata_i;
    end

    assign head_o  = mem_q[head_q];
    assign count_o = count_q;

endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end: PC register, imem addressing, redirect flush and a
// decoupling queue of {pc, instr} pairs feeding decode.
module fetch_queue
    import riscv_pkg::*;
#(
    parameter int unsigned     XLEN      = riscv_pkg::XLEN,
    parameter int unsigned     DEPTH     = 4,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [31:0]     NOP_INSTR = riscv_pkg::NOP_INSTR
) (
    input  logic          clk,
    input  logic          rst,
    fetch_queue_if.slave  bus
);

    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam int unsigned EntW = XLEN + ILEN;

    logic [XLEN-1:0] pc_q, pc_d;
    logic            mis_q, mis_d;
    logic            push, pop, out_valid;
    logic [EntW-1:0] head;
    logic [CntW-1:0] count;

    assign out_valid = (count != '0);
    // Redirect masks both strobes so a wrong-path head is never consumed.
    assign pop  = out_valid & bus.out_ready & ~bus.redirect_valid;
    assign push = bus.fetch_en & ((count < CntW'(DEPTH)) | pop) & ~bus.redirect_valid;

    always_comb begin
        pc_d  = pc_q;
        mis_d = bus.redirect_valid & (bus.redirect_pc[1:0] != 2'b00);
        if (bus.redirect_valid) pc_d = {bus.redirect_pc[XLEN-1:2], 2'b00};
        else if (push)          pc_d = pc_q + XLEN'(4);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q  <= RESET_PC;
            mis_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            mis_q <= mis_d;
        end
    end

    fetch_fifo #(
        .WIDTH (EntW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .pop_i   (pop),
        .clear_i (bus.redirect_valid),
        .wdata_i ({pc_q, bus.imem_instr}),
        .head_o  (head),
        .count_o (count)
    );

    assign bus.imem_addr  = pc_q;
    assign bus.out_valid  = out_valid;
    assign bus.out_pc     = out_valid ? head[EntW-1:ILEN] : '0;
    assign bus.out_instr  = out_valid ? head[ILEN-1:0] : NOP_INSTR;
    assign bus.out_pc4    = bus.out_pc + XLEN'(4);
    assign bus.count      = count;
    assign bus.misaligned = mis_q;

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios plus a randomized run against a queue-based model.
module tb_fetch_queue;
    import riscv_pkg::*;

    localparam int unsigned DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] key = 32'hA5;
    int          checks = 0;
    int          errors = 0;

    fetch_queue_if #(.XLEN(32), .DEPTH(DEPTH)) bus ();

    assign bus.imem_instr = bus.imem_addr ^ key;

    fetch_queue #(
        .XLEN      (32),
        .DEPTH     (DEPTH),
        .RESET_PC  (RESET_PC),
        .NOP_INSTR (NOP)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: a plain queue of fetched entries plus the next fetch PC.
    fetch_entry_t m_q[$];
    logic [31:0]  m_pc  = RESET_PC;
    logic         m_mis = 1'b0;
    bit           m_pop, m_push;

    initial forever begin
        @(posedge clk or posedge rst);
        if (rst) begin
            m_q.delete();
            m_pc  = RESET_PC;
            m_mis = 1'b0;
        end else begin
            m_pop  = (m_q.size() != 0) && bus.out_ready && !bus.redirect_valid;
            m_push = bus.fetch_en && (m_q.size() < DEPTH || m_pop) && !bus.redirect_valid;
            m_mis  = bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
            if (bus.redirect_valid) begin
                m_q.delete();
                m_pc = bus.redirect_pc & ~32'h3;
            end else begin
                if (m_pop) void'(m_q.pop_front());
                if (m_push) begin
                    m_q.push_back('{pc: m_pc, instr: m_pc ^ key});
                    m_pc = m_pc + 32'd4;
                end
            end
        end
    end

    task automatic restart();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        bus.fetch_en = 1'b0; bus.out_ready = 1'b0;
        bus.redirect_valid = 1'b0; bus.redirect_pc = '0;
        rst = 1'b1;
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", bus.out_valid); end
        checks++; if (bus.out_instr !== NOP) begin errors++; $display("FAIL reset_instr got %h want %h", bus.out_instr, NOP); end
        checks++; if (bus.out_pc !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want 0", bus.out_pc); end
        checks++; if (bus.out_pc4 !== 32'h4) begin errors++; $display("FAIL reset_pc4 got %h want 4", bus.out_pc4); end
        checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", bus.count); end
        checks++; if (bus.imem_addr !== RESET_PC) begin errors++; $display("FAIL reset_addr got %h want %h", bus.imem_addr, RESET_PC); end
        checks++; if (bus.misaligned !== 1'b0) begin errors++; $display("FAIL reset_mis got %0b want 0", bus.misaligned); end
    endtask

    task automatic test_stream();
        key = 32'hA5; bus.fetch_en = 1'b1; bus.out_ready = 1'b1;
        restart();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d] got %0b want 1", k, bus.out_valid); end
            checks++; if (bus.out_pc !== 32'(4 * k)) begin errors++; $display("FAIL stream_pc[%0d] got %h want %h", k, bus.out_pc, 32'(4 * k)); end
            checks++; if (bus.out_pc4 !== 32'(4 * k + 4)) begin errors++; $display("FAIL stream_pc4[%0d] got %h want %h", k, bus.out_pc4, 32'(4 * k + 4)); end
            checks++; if (bus.out_instr !== (32'(4 * k) ^ 32'hA5)) begin errors++; $display("FAIL stream_instr[%0d] got %h want %h", k, bus.out_instr, 32'(4 * k) ^ 32'hA5); end
        end
    endtask

    task automatic test_stall();
        bus.fetch_en = 1'b1; bus.out_ready = 1'b0;
        restart();
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            checks++; if (bus.count !== 3'((k > 4) ? 4 : k)) begin errors++; $display("FAIL stall_count[%0d] got %0d want %0d", k, bus.count, (k > 4) ? 4 : k); end
            checks++; if (bus.out_pc !== 32'h0) begin errors++; $display("FAIL stall_head[%0d] got %h want 0", k, bus.out_pc); end
        end
        checks++; if (bus.imem_addr !== 32'd16) begin errors++; $display("FAIL stall_addr got %h want 10", bus.imem_addr); end
        bus.out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'(4 * k)) begin errors++; $display("FAIL drain_pc[%0d] got %0b/%h want 1/%h", k, bus.out_valid, bus.out_pc, 32'(4 * k)); end
            @(negedge clk);
        end
    endtask

    task automatic test_redirect();
        bus.fetch_en = 1'b1; bus.out_ready = 1'b0;
        restart();
        repeat (4) @(negedge clk);
        checks++; if (bus.count !== 3'd4) begin errors++; $display("FAIL redir_full got %0d want 4", bus.count); end
        bus.out_ready = 1'b1; bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h100;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        checks++; if (bus.count !== 3'd0) begin errors++; $display("FAIL redir_count got %0d want 0", bus.count); end
        checks++; if (bus.imem_addr !== 32'h100) begin errors++; $display("FAIL redir_addr got %h want 100", bus.imem_addr); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL redir_valid got %0b want 0", bus.out_valid); end
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 32'h100) begin errors++; $display("FAIL redir_head got %0b/%h want 1/100", bus.out_valid, bus.out_pc); end
        checks++; if (bus.misaligned !== 1'b0) begin errors++; $display("FAIL redir_mis got %0b want 0", bus.misaligned); end
        bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0000_0203;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        checks++; if (bus.imem_addr !== 32'h200) begin errors++; $display("FAIL misal_addr got %h want 200", bus.imem_addr); end
        checks++; if (bus.misaligned !== 1'b1) begin errors++; $display("FAIL misal_pulse got %0b want 1", bus.misaligned); end
        @(negedge clk);
        checks++; if (bus.misaligned !== 1'b0) begin errors++; $display("FAIL misal_clear got %0b want 0", bus.misaligned); end
        checks++; if (bus.out_pc !== 32'h200) begin errors++; $display("FAIL misal_head got %h want 200", bus.out_pc); end
        bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h300;
        @(negedge clk);
        bus.redirect_pc = 32'h400;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        checks++; if (bus.imem_addr !== 32'h400 || bus.count !== 3'd0) begin errors++; $display("FAIL b2b_addr got %h/%0d want 400/0", bus.imem_addr, bus.count); end
        @(negedge clk);
        checks++; if (bus.out_pc !== 32'h400) begin errors++; $display("FAIL b2b_head got %h want 400", bus.out_pc); end
    endtask

    task automatic test_wrap();
        bus.fetch_en = 1'b1; bus.out_ready = 1'b0;
        bus.redirect_valid = 1'b1; bus.redirect_pc = 32'hFFFF_FFFC;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        checks++; if (bus.imem_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr0 got %h want fffffffc", bus.imem_addr); end
        @(negedge clk);
        checks++; if (bus.out_pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_head got %h want fffffffc", bus.out_pc); end
        checks++; if (bus.out_pc4 !== 32'h0) begin errors++; $display("FAIL wrap_pc4 got %h want 0", bus.out_pc4); end
        checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr1 got %h want 0", bus.imem_addr); end
    endtask

    task automatic test_async_reset();
        bus.fetch_en = 1'b1; bus.out_ready = 1'b0; bus.redirect_valid = 1'b0;
        restart();
        repeat (3) @(negedge clk);
        checks++; if (bus.count !== 3'd3) begin errors++; $display("FAIL arst_pre got %0d want 3", bus.count); end
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.out_valid !== 1'b0 || bus.count !== 3'd0) begin errors++; $display("FAIL arst_clear got %0b/%0d want 0/0", bus.out_valid, bus.count); end
        checks++; if (bus.out_instr !== NOP) begin errors++; $display("FAIL arst_instr got %h want %h", bus.out_instr, NOP); end
        @(negedge clk);
        rst = 1'b0; bus.out_ready = 1'b1;
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b1 || bus.out_pc !== RESET_PC) begin errors++; $display("FAIL arst_restart got %0b/%h want 1/%h", bus.out_valid, bus.out_pc, RESET_PC); end
        checks++; if (bus.imem_addr !== RESET_PC + 32'd4) begin errors++; $display("FAIL arst_addr got %h want %h", bus.imem_addr, RESET_PC + 32'd4); end
    endtask

    task automatic test_random();
        logic        e_valid;
        logic [31:0] e_pc, e_instr;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            e_valid = (m_q.size() != 0);
            e_pc    = e_valid ? m_q[0].pc : 32'h0;
            e_instr = e_valid ? m_q[0].instr : NOP;
            checks++; if (bus.out_valid !== e_valid) begin errors++; $display("FAIL rnd_valid[%0d] got %0b want %0b", n, bus.out_valid, e_valid); end
            checks++; if (bus.out_pc !== e_pc) begin errors++; $display("FAIL rnd_pc[%0d] got %h want %h", n, bus.out_pc, e_pc); end
            checks++; if (bus.out_pc4 !== e_pc + 32'd4) begin errors++; $display("FAIL rnd_pc4[%0d] got %h want %h", n, bus.out_pc4, e_pc + 32'd4); end
            checks++; if (bus.out_instr !== e_instr) begin errors++; $display("FAIL rnd_instr[%0d] got %h want %h", n, bus.out_instr, e_instr); end
            checks++; if (bus.count !== 3'(m_q.size())) begin errors++; $display("FAIL rnd_count[%0d] got %0d want %0d", n, bus.count, m_q.size()); end
            checks++; if (bus.imem_addr !== m_pc) begin errors++; $display("FAIL rnd_addr[%0d] got %h want %h", n, bus.imem_addr, m_pc); end
            checks++; if (bus.misaligned !== m_mis) begin errors++; $display("FAIL rnd_mis[%0d] got %0b want %0b", n, bus.misaligned, m_mis); end
            bus.fetch_en       = ($urandom_range(9) < 8);
            bus.out_ready      = ($urandom_range(9) < 6);
            bus.redirect_valid = ($urandom_range(9) == 0);
            bus.redirect_pc    = $urandom;
            if ($urandom_range(3) == 0) bus.redirect_pc[31:4] = 28'hFFF_FFFF;
            if ($urandom_range(15) == 0) key = $urandom;
        end
        bus.redirect_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect();
        test_wrap();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
